// File: rtl/wave_rom_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : wave_rom_sched_if
// Brief    : Player-array / ROM / request-source bundle for wave_rom_sched.
// Revision : 1.0
// ============================================================================
interface wave_rom_sched_if #(
  parameter int NCH = 8,
  parameter int AW  = 17
);
  logic [3:0]       O_H_CNT;
  logic [NCH*AW-1:0] I_CH_ADDR;
  logic [AW-1:0]    O_ROM_ADDR;
  logic [7:0]       I_ROM_DATA;
  logic [NCH*8-1:0] O_CH_DATA;
  logic             I_REQ_VALID;
  logic [2:0]       I_REQ_CHAN;
  logic [AW-1:0]    I_REQ_ADDR;
  logic             O_REQ_READY;
  logic [NCH-1:0]   O_TRIG;
  logic [AW-1:0]    O_TRIG_ADDR;
  logic [2:0]       O_QCOUNT;

  modport slave (
    output O_H_CNT, O_ROM_ADDR, O_CH_DATA, O_REQ_READY, O_TRIG, O_TRIG_ADDR, O_QCOUNT,
    input  I_CH_ADDR, I_ROM_DATA, I_REQ_VALID, I_REQ_CHAN, I_REQ_ADDR
  );

  modport master (
    input  O_H_CNT, O_ROM_ADDR, O_CH_DATA, O_REQ_READY, O_TRIG, O_TRIG_ADDR, O_QCOUNT,
    output I_CH_ADDR, I_ROM_DATA, I_REQ_VALID, I_REQ_CHAN, I_REQ_ADDR
  );
endinterface
`default_nettype wire

// File: rtl/wave_rom_sched.sv
`default_nettype none
// ============================================================================
// Module   : wave_rom_sched
// Brief    : Shares one wave ROM port among NCH players and dispatches triggers.
// Revision : 1.0
// ============================================================================
module wave_rom_sched #(
  parameter int NCH     = 8,
  parameter int AW      = 17,
  parameter int ROM_LAT = 2,
  parameter int QDEPTH  = 4
) (
  input  logic           I_CLK,
  input  logic           I_RST,
  wave_rom_sched_if.slave bus
);

  localparam int         c_PW     = $clog2(QDEPTH);
  localparam logic [2:0] c_QDEPTH = 3'(QDEPTH);
  localparam logic [NCH-1:0] c_ONE = NCH'(1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_FIRE = 2'd1;
  localparam logic [1:0] c_GAP  = 2'd2;

  // ---------------- slot counter, address mux, data return ----------------
  logic [3:0]       r_h_cnt;
  logic [AW-1:0]    r_rom_addr;
  logic             r_tag_vld [ROM_LAT];
  logic [2:0]       r_tag_ch  [ROM_LAT];
  logic [NCH*8-1:0] r_ch_data;

  logic [2:0]    w_slot_ch;
  logic          w_addr_phase;
  logic [AW-1:0] w_sel_addr;

  assign w_slot_ch    = r_h_cnt[3:1];
  assign w_addr_phase = ~r_h_cnt[0];
  assign w_sel_addr   = bus.I_CH_ADDR[int'(w_slot_ch)*AW +: AW];

  // The tag pipeline mirrors the ROM latency so each returned byte knows its owner.
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      r_h_cnt    <= 4'd0;
      r_rom_addr <= '0;
      r_ch_data  <= '0;
      for (int i = 0; i < ROM_LAT; i++) begin
        r_tag_vld[i] <= 1'b0;
        r_tag_ch[i]  <= 3'd0;
      end
    end else begin
      r_h_cnt <= r_h_cnt + 4'd1;
      if (w_addr_phase) begin
        r_rom_addr <= w_sel_addr;
      end
      r_tag_vld[0] <= w_addr_phase;
      r_tag_ch[0]  <= w_slot_ch;
      for (int i = 1; i < ROM_LAT; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_ch[i]  <= r_tag_ch[i-1];
      end
      if (r_tag_vld[ROM_LAT-1]) begin
        r_ch_data[int'(r_tag_ch[ROM_LAT-1])*8 +: 8] <= bus.I_ROM_DATA;
      end
    end
  end

  // ---------------- request FIFO ----------------
  logic [2:0]      r_fifo_chan [QDEPTH];
  logic [AW-1:0]   r_fifo_addr [QDEPTH];
  logic [c_PW-1:0] r_wr_ptr;
  logic [c_PW-1:0] r_rd_ptr;
  logic [2:0]      r_qcount;

  logic [1:0]     r_state;
  logic [3:0]     r_cnt;
  logic [NCH-1:0] r_trig;
  logic [AW-1:0]  r_trig_addr;

  logic w_full;
  logic w_ready;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_qcount == c_QDEPTH);
  assign w_ready = ~w_full & ~I_RST;
  assign w_push  = bus.I_REQ_VALID & w_ready;
  assign w_pop   = (r_state == c_IDLE) && (r_qcount != 3'd0);

  always_ff @(posedge I_CLK) begin
    if (w_push) begin
      r_fifo_chan[r_wr_ptr] <= bus.I_REQ_CHAN;
      r_fifo_addr[r_wr_ptr] <= bus.I_REQ_ADDR;
    end
  end

  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_qcount <= 3'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_qcount <= r_qcount + 3'd1;
        2'b01:   r_qcount <= r_qcount - 3'd1;
        default: r_qcount <= r_qcount;
      endcase
    end
  end

  // ---------------- dispatcher ----------------
  // FIRE lasts a full 16-slot rotation so every player sees the level.
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      r_state     <= c_IDLE;
      r_cnt       <= 4'd0;
      r_trig      <= '0;
      r_trig_addr <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_pop) begin
            r_trig      <= c_ONE << r_fifo_chan[r_rd_ptr];
            r_trig_addr <= r_fifo_addr[r_rd_ptr];
            r_cnt       <= 4'd0;
            r_state     <= c_FIRE;
          end
        end
        c_FIRE: begin
          if (r_cnt == 4'd15) begin
            r_trig  <= '0;
            r_cnt   <= 4'd0;
            r_state <= c_GAP;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        c_GAP: begin
          if (r_cnt == 4'd1) begin
            r_cnt   <= 4'd0;
            r_state <= c_IDLE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: begin
          r_trig  <= '0;
          r_cnt   <= 4'd0;
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign bus.O_H_CNT     = r_h_cnt;
  assign bus.O_ROM_ADDR  = r_rom_addr;
  assign bus.O_CH_DATA   = r_ch_data;
  assign bus.O_REQ_READY = w_ready;
  assign bus.O_TRIG      = r_trig;
  assign bus.O_TRIG_ADDR = r_trig_addr;
  assign bus.O_QCOUNT    = r_qcount;

endmodule
`default_nettype wire

// File: tb/tb_wave_rom_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_wave_rom_sched
// Brief    : Self-checking bench for wave_rom_sched against a queue/timeline model.
// Revision : 1.0
// ============================================================================
module tb_wave_rom_sched;

  localparam int NCH     = 8;
  localparam int AW      = 17;
  localparam int ROM_LAT = 2;
  localparam int QDEPTH  = 4;

  logic I_CLK = 1'b0;
  logic I_RST = 1'b0;

  wave_rom_sched_if #(.NCH(NCH), .AW(AW)) bus ();

  wave_rom_sched #(.NCH(NCH), .AW(AW), .ROM_LAT(ROM_LAT), .QDEPTH(QDEPTH)) dut (
    .I_CLK (I_CLK),
    .I_RST (I_RST),
    .bus   (bus)
  );

  always #5 I_CLK = ~I_CLK;

  // Synchronous ROM: byte for an address is sampled by the DUT two edges after it loads.
  logic [7:0] rom_q = 8'h00;
  always @(posedge I_CLK) rom_q <= bus.O_ROM_ADDR[7:0] ^ 8'hA5;
  assign bus.I_ROM_DATA = rom_q;

  typedef struct { int chan; logic [AW-1:0] addr; } req_t;
  typedef struct { int due; int ch; logic [7:0] val; } pend_t;

  int checks   = 0;
  int failures = 0;

  int            m_h;
  int            m_age;
  int            m_trig_ch;
  int            n_edge;
  logic [AW-1:0] m_rom_addr;
  logic [AW-1:0] m_trig_addr;
  logic [7:0]    m_ch_data [NCH];
  req_t          m_q [$];
  pend_t         m_pend [$];
  logic          last_push;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_h         = 0;
    m_age       = 100;
    m_trig_ch   = 0;
    n_edge      = 0;
    m_rom_addr  = '0;
    m_trig_addr = '0;
    for (int c = 0; c < NCH; c++) m_ch_data[c] = 8'h00;
    m_q.delete();
    m_pend.delete();
  endtask

  function automatic logic [63:0] exp_ch_data();
    logic [63:0] v = '0;
    for (int c = 0; c < NCH; c++) v[c*8 +: 8] = m_ch_data[c];
    return v;
  endfunction

  function automatic logic [63:0] exp_trig();
    return (m_age <= 15) ? (64'd1 << m_trig_ch) : 64'd0;
  endfunction

  task automatic check_all();
    chk("h_cnt",     bus.O_H_CNT,     64'(m_h));
    chk("rom_addr",  bus.O_ROM_ADDR,  m_rom_addr);
    chk("ch_data",   bus.O_CH_DATA,   exp_ch_data());
    chk("trig",      bus.O_TRIG,      exp_trig());
    chk("trig_addr", bus.O_TRIG_ADDR, m_trig_addr);
    chk("qcount",    bus.O_QCOUNT,    64'(m_q.size()));
    chk("ready",     bus.O_REQ_READY, 64'(!I_RST && m_q.size() < QDEPTH));
  endtask

  // Advance one clock: model consumes the pre-edge inputs, then outputs are compared.
  task automatic step();
    logic  push, pop;
    int    ch, i;
    req_t  r;
    pop  = (m_age >= 18) && (m_q.size() > 0);
    push = bus.I_REQ_VALID && (m_q.size() < QDEPTH);
    i = 0;
    while (i < m_pend.size()) begin
      if (m_pend[i].due == n_edge + 1) begin
        m_ch_data[m_pend[i].ch] = m_pend[i].val;
        m_pend.delete(i);
      end else begin
        i++;
      end
    end
    if (m_h % 2 == 0) begin
      ch = m_h / 2;
      m_rom_addr = bus.I_CH_ADDR[ch*AW +: AW];
      m_pend.push_back('{n_edge + 1 + ROM_LAT, ch, m_rom_addr[7:0] ^ 8'hA5});
    end
    if (pop) begin
      r = m_q.pop_front();
      m_trig_ch   = r.chan;
      m_trig_addr = r.addr;
      m_age       = 0;
    end else if (m_age < 100) begin
      m_age++;
    end
    if (push) m_q.push_back('{int'(bus.I_REQ_CHAN), bus.I_REQ_ADDR});
    last_push = push;
    m_h = (m_h + 1) % 16;
    n_edge++;
    @(posedge I_CLK);
    #1;
    check_all();
  endtask

  task automatic set_req(input logic v, input logic [2:0] ch, input logic [AW-1:0] a);
    bus.I_REQ_VALID = v;
    bus.I_REQ_CHAN  = ch;
    bus.I_REQ_ADDR  = a;
  endtask

  task automatic drain();
    int guard = 0;
    while ((m_q.size() > 0 || m_age < 18) && guard < 300) begin
      step();
      guard++;
    end
    chk("drain_bound", 64'(guard < 300), 64'd1);
  endtask

  initial begin
    int      cnt, guard, idx, e1, e2;
    logic    prev;
    req_t    bp [6];
    logic [7:0] q_max;

    set_req(1'b0, 3'd0, '0);
    for (int c = 0; c < NCH; c++) bus.I_CH_ADDR[c*AW +: AW] = AW'(32'h100 * c + 5);
    model_reset();

    // Reset values
    #1 I_RST = 1'b1;
    #2 check_all();
    repeat (2) @(posedge I_CLK);
    #4 I_RST = 1'b0;
    #1 chk("ready_after_reset", bus.O_REQ_READY, 64'd1);

    // Slot / address rotation and data routing
    for (int i = 0; i < 32; i++) step();
    chk("ch3_byte", bus.O_CH_DATA[3*8 +: 8], 64'hA0);

    // Single request chan 5 into an empty FIFO
    set_req(1'b1, 3'd5, 17'h1234);
    step();
    set_req(1'b0, 3'd0, '0);
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (bus.O_TRIG === 8'h20 && bus.O_TRIG_ADDR === 17'h1234) cnt++;
    end
    chk("single_trig_cycles", 64'(cnt), 64'd16);
    drain();

    // Backpressure: VALID held across six requests
    for (int i = 0; i < 6; i++) bp[i] = '{(i + 1) % NCH, AW'(32'h200 + 32'h11 * i)};
    idx = 0; guard = 0; q_max = 0;
    while (idx < 6 && guard < 200) begin
      set_req(1'b1, 3'(bp[idx].chan), bp[idx].addr);
      step();
      if (bus.O_QCOUNT > q_max) q_max = 8'(bus.O_QCOUNT);
      if (last_push) idx++;
      guard++;
    end
    set_req(1'b0, 3'd0, '0);
    chk("bp_bound", 64'(guard < 200), 64'd1);
    chk("bp_full_depth", 64'(q_max), 64'(QDEPTH));
    drain();

    // Back-to-back requests to channel 2
    set_req(1'b1, 3'd2, 17'h0AAA); step();
    set_req(1'b1, 3'd2, 17'h0BBB); step();
    set_req(1'b0, 3'd0, '0);
    prev = bus.O_TRIG[2]; e1 = (prev === 1'b1) ? n_edge : -1; e2 = -1;
    for (int i = 0; i < 45; i++) begin
      step();
      if (bus.O_TRIG[2] === 1'b1 && prev !== 1'b1) begin
        if (e1 < 0) e1 = n_edge; else if (e2 < 0) e2 = n_edge;
      end
      prev = bus.O_TRIG[2];
    end
    chk("b2b_rise_spacing", 64'(e2 - e1), 64'd19);
    drain();

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      set_req(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), AW'($urandom));
      if ($urandom_range(0, 7) == 0) bus.I_CH_ADDR[$urandom_range(0, NCH-1)*AW +: AW] = AW'($urandom);
      step();
    end
    set_req(1'b0, 3'd0, '0);
    drain();

    // Asynchronous reset in the middle of FIRE with two requests queued
    set_req(1'b1, 3'd1, 17'h0111); step();
    set_req(1'b1, 3'd4, 17'h0444); step();
    set_req(1'b1, 3'd6, 17'h0666); step();
    set_req(1'b0, 3'd0, '0);
    for (int i = 0; i < 7; i++) step();
    chk("pre_reset_qcount", bus.O_QCOUNT, 64'd2);
    #3 I_RST = 1'b1;
    model_reset();
    #1 check_all();
    repeat (2) @(posedge I_CLK);
    #4 I_RST = 1'b0;
    #1 chk("ready_after_midfire_reset", bus.O_REQ_READY, 64'd1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.O_TRIG !== 8'h00) cnt++;
    end
    chk("no_trig_after_reset", 64'(cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
